// File: rtl/cache_mem_arbiter_pkg.sv
// Shared word/RAM-state types, arbiter FSM states and the load word returned on a failed read.
package cache_mem_arbiter_pkg;

  localparam int WORD_W        = 32;
  localparam int MAX_RETRY_DEF = 3;
  localparam int TIMEOUT_DEF   = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_XFER = 3'd1,
    I_XFER = 3'd2,
    RETRY  = 3'd3,
    GAP    = 3'd4
  } memarb_state_t;

  localparam word_t ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM handshake bundle: dcache + icache request side and the single RAM port.
interface cache_mem_arbiter_if;
  import cache_mem_arbiter_pkg::*;

  logic      dREN, dWEN, dwait;
  word_t     daddr, dstore, dload;
  logic      iREN, iwait;
  word_t     iaddr, iload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      ram_err, busy;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err, busy
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err, busy
  );

endinterface

// File: rtl/cache_mem_arbiter_retry_timer.sv
// Per-request timeout and retry counters; fault decision is combinational in the faulting cycle.
// No backpressure: retry_o/give_up_o are single-cycle pulses, counters cleared while clear_i is high.
module cache_mem_arbiter_retry_timer #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear_i,
  input  logic active_i,
  input  logic access_i,
  input  logic error_i,
  output logic retry_o,
  output logic give_up_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [TW-1:0] tmo_q;
  logic [RW-1:0] retry_q;
  logic          fault;

  // The TIMEOUT-th transfer cycle without ACCESS counts like an ERROR response.
  assign fault     = active_i && !access_i && (error_i || (tmo_q == TMO_LAST));
  assign retry_o   = fault && (retry_q < RETRY_MAX);
  assign give_up_o = fault && !(retry_q < RETRY_MAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else if (clear_i) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else if (fault) begin
      tmo_q <= '0;
      if (retry_q != '1) retry_q <= retry_q + 1'b1;
    end else if (active_i && (tmo_q != TMO_LAST)) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serves dcache (priority) and icache word requests on one RAM port; completion = 1 cycle + RAM latency.
// Requesters are held off by dwait/iwait; one GAP cycle after each completion absorbs stale requests.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic                 CLK,
  input logic                 nRST,
  cache_mem_arbiter_if.slave  bus
);

  memarb_state_t state_q;
  logic          is_d_q, wr_q, ren_q, wen_q, err_q, busy_q;
  word_t         addr_q, store_q;

  logic  xfer, access, retry, give_up, complete, d_done, i_done;
  word_t load_val;

  assign xfer     = (state_q == D_XFER) || (state_q == I_XFER);
  assign access   = xfer && (bus.ramstate == ACCESS);
  assign complete = access || give_up;
  assign d_done   = complete && (state_q == D_XFER);
  assign i_done   = complete && (state_q == I_XFER);
  // A failed write simply reports completion; only reads carry the error marker.
  assign load_val = give_up ? (wr_q ? '0 : ERR_WORD) : bus.ramload;

  assign bus.dwait    = !d_done;
  assign bus.iwait    = !i_done;
  assign bus.dload    = d_done ? load_val : '0;
  assign bus.iload    = i_done ? load_val : '0;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ram_err  = err_q;
  assign bus.busy     = busy_q;

  cache_mem_arbiter_retry_timer #(
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear_i   (state_q == IDLE),
    .active_i  (xfer),
    .access_i  (access),
    .error_i   (bus.ramstate == ERROR),
    .retry_o   (retry),
    .give_up_o (give_up)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      is_d_q  <= 1'b0;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.dREN || bus.dWEN) begin
            state_q <= D_XFER;
            is_d_q  <= 1'b1;
            wr_q    <= bus.dWEN;
            ren_q   <= !bus.dWEN;
            wen_q   <= bus.dWEN;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            busy_q  <= 1'b1;
          end else if (bus.iREN) begin
            state_q <= I_XFER;
            is_d_q  <= 1'b0;
            wr_q    <= 1'b0;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= bus.iaddr;
            busy_q  <= 1'b1;
          end
        end
        D_XFER, I_XFER: begin
          if (complete) begin
            state_q <= GAP;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            if (give_up) err_q <= 1'b1;
          end else if (retry) begin
            state_q <= RETRY;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end
        end
        RETRY: begin
          state_q <= is_d_q ? D_XFER : I_XFER;
          ren_q   <= !wr_q;
          wen_q   <= wr_q;
        end
        GAP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
